// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types and widths for the IFU/LSU data-memory arbiter.
package lsu_mem_arbiter_pkg;

    // Bus widths shared by the arbiter, its interface and its selector.
    localparam int XLEN     = 64;
    localparam int ADDR_W   = 32;
    localparam int MASK_W   = XLEN / 8;

    // Wide enough for the largest legal streak limit (15).
    localparam int STREAK_W = 4;

    typedef logic [XLEN-1:0]     xlen_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [MASK_W-1:0]   mask_t;
    typedef logic [STREAK_W-1:0] streak_t;

    // Transaction FSM: grant in IDLE, present downstream in REQ, await response in WAIT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Which requester owns the outstanding transaction.
    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_t;

    // Bit positions inside the selector's grant vector.
    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// Bundles the IFU, LSU and downstream memory handshakes around the arbiter.
// The slave view belongs to the arbiter; the master view belongs to whatever
// drives the requesters and models the memory.
interface lsu_mem_arbiter_if;
    import lsu_mem_arbiter_pkg::*;

    logic  ifu_req_i;
    addr_t ifu_addr_i;
    logic  ifu_gnt_o;
    logic  ifu_rvalid_o;
    xlen_t ifu_rdata_o;

    logic  lsu_req_i;
    logic  lsu_wen_i;
    addr_t lsu_addr_i;
    mask_t lsu_mask_i;
    xlen_t lsu_wdata_i;
    logic  lsu_gnt_o;
    logic  lsu_rvalid_o;
    xlen_t lsu_rdata_o;

    logic  mem_req_o;
    logic  mem_wen_o;
    addr_t mem_addr_o;
    mask_t mem_mask_o;
    xlen_t mem_wdata_o;
    logic  mem_gnt_i;
    logic  mem_rvalid_i;
    xlen_t mem_rdata_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
        input  lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_mask_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        output mem_req_o, mem_wen_o, mem_addr_o, mem_mask_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
        output lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_mask_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        input  mem_req_o, mem_wen_o, mem_addr_o, mem_mask_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_mem_arb_sel.sv
// Priority selector between IFU and LSU with an anti-starvation streak counter.
// LSU wins contested cycles until it has won MAX_LSU_STREAK of them in a row,
// then the IFU is forced through once.
module lsu_mem_arb_sel
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4   // legal range 1..15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arb_en_i,
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    output logic [1:0] gnt_o,
    output owner_t     owner_o
);

    localparam streak_t STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

    streak_t streak_q;
    logic    ifu_forced;

    assign ifu_forced = (streak_q == STREAK_MAX);

    // Pick at most one requester while the arbiter is idle.
    always_comb begin
        gnt_o   = '0;
        owner_o = OWNER_IFU;
        if (arb_en_i) begin
            if (lsu_req_i && !(ifu_req_i && ifu_forced)) begin
                gnt_o[GNT_LSU] = 1'b1;
                owner_o        = OWNER_LSU;
            end else if (ifu_req_i) begin
                gnt_o[GNT_IFU] = 1'b1;
            end
        end
    end

    // Count contested LSU wins; any IFU grant clears the streak.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else if (gnt_o[GNT_IFU]) begin
            streak_q <= '0;
        end else if (gnt_o[GNT_LSU] && ifu_req_i && (streak_q != STREAK_MAX)) begin
            streak_q <= streak_q + streak_t'(1);
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port between the IFU and the LSU. One transaction is
// outstanding at a time: the chosen request is latched on its grant, presented
// downstream until accepted, and the response is routed back to its owner.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4   // legal range 1..15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    lsu_mem_arbiter_if.slave  bus
);

    state_t     state_q;
    owner_t     owner_q;
    addr_t      addr_q;
    mask_t      mask_q;
    xlen_t      wdata_q;
    logic       wen_q;
    logic       mem_req_q;

    logic [1:0] gnt;
    owner_t     sel_owner;
    logic       arb_en;
    logic       resp;

    // Grants are only offered from IDLE and never while reset is held.
    assign arb_en = (state_q == ST_IDLE) && !rst_i;

    // A response only counts once the request has been accepted downstream.
    assign resp   = (state_q == ST_WAIT) && bus.mem_rvalid_i && !rst_i;

    lsu_mem_arb_sel #(
        .MAX_LSU_STREAK (MAX_LSU_STREAK)
    ) u_sel (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .arb_en_i  (arb_en),
        .ifu_req_i (bus.ifu_req_i),
        .lsu_req_i (bus.lsu_req_i),
        .gnt_o     (gnt),
        .owner_o   (sel_owner)
    );

    // Transaction FSM with the request latches and the registered downstream request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_IFU;
            addr_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner_q   <= sel_owner;
                        state_q   <= ST_REQ;
                        mem_req_q <= 1'b1;
                        if (sel_owner == OWNER_LSU) begin
                            addr_q  <= bus.lsu_addr_i;
                            mask_q  <= bus.lsu_mask_i;
                            wdata_q <= bus.lsu_wdata_i;
                            wen_q   <= bus.lsu_wen_i;
                        end else begin
                            addr_q  <= bus.ifu_addr_i;
                            mask_q  <= '1;
                            wdata_q <= '0;
                            wen_q   <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Grants come straight from the selector so the requester sees them in the same cycle.
    assign bus.ifu_gnt_o    = gnt[GNT_IFU];
    assign bus.lsu_gnt_o    = gnt[GNT_LSU];

    // Route the response to its owner; data is zero whenever valid is low and for stores.
    assign bus.ifu_rvalid_o = resp && (owner_q == OWNER_IFU);
    assign bus.lsu_rvalid_o = resp && (owner_q == OWNER_LSU);
    assign bus.ifu_rdata_o  = bus.ifu_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.lsu_rdata_o  = (bus.lsu_rvalid_o && !wen_q) ? bus.mem_rdata_i : '0;

    // Downstream request fields come only from the latches, so they hold until granted.
    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_wen_o    = wen_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_mask_o   = mask_q;
    assign bus.mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: directed vector table, hand-written
// corner sequences, and randomized transactions against a behavioural model.
module tb_lsu_mem_arbiter;
    import lsu_mem_arbiter_pkg::*;

    localparam int MAX_STREAK = 2;
    localparam int NUM_VECS   = 6;
    localparam int NUM_RAND   = 150;

    typedef struct {
        logic        ifu_req;
        logic [31:0] ifu_addr;
        logic        lsu_req;
        logic        lsu_wen;
        logic [31:0] lsu_addr;
        logic [7:0]  lsu_mask;
        logic [63:0] lsu_wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [63:0] rdata;
        logic        exp_lsu;
        logic        exp_wen;
        logic [31:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   total = 0;
    int   bad   = 0;
    int   model_streak;
    vec_t vecs [NUM_VECS];

    always #5 clk_i = ~clk_i;

    lsu_mem_arbiter_if bus ();

    lsu_mem_arbiter #(
        .MAX_LSU_STREAK (MAX_STREAK)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        bus.ifu_req_i    = 1'b0;
        bus.ifu_addr_i   = '0;
        bus.lsu_req_i    = 1'b0;
        bus.lsu_wen_i    = 1'b0;
        bus.lsu_addr_i   = '0;
        bus.lsu_mask_i   = '0;
        bus.lsu_wdata_i  = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst_i = 1'b1;
        nextCycle();
        nextCycle();
        rst_i = 1'b0;
        model_streak = 0;
    endtask

    // Scramble requester inputs while a transaction is in flight.
    task automatic noiseInputs(input bit noisy);
        bus.ifu_req_i   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.lsu_req_i   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ifu_addr_i  = $urandom;
        bus.lsu_addr_i  = $urandom;
        bus.lsu_wen_i   = 1'($urandom_range(0, 1));
        bus.lsu_mask_i  = 8'($urandom);
        bus.lsu_wdata_i = {$urandom, $urandom};
    endtask

    // Run one full transaction from an IDLE cycle and check every cycle of it.
    task automatic applyStimulus(input vec_t v, input string tag, input bit noisy);
        bus.ifu_req_i   = v.ifu_req;
        bus.ifu_addr_i  = v.ifu_addr;
        bus.lsu_req_i   = v.lsu_req;
        bus.lsu_wen_i   = v.lsu_wen;
        bus.lsu_addr_i  = v.lsu_addr;
        bus.lsu_mask_i  = v.lsu_mask;
        bus.lsu_wdata_i = v.lsu_wdata;
        @(negedge clk_i);
        checkOutput({tag, " ifu_gnt"}, 64'(bus.ifu_gnt_o), 64'(!v.exp_lsu));
        checkOutput({tag, " lsu_gnt"}, 64'(bus.lsu_gnt_o), 64'(v.exp_lsu));
        checkOutput({tag, " idle_req"}, 64'(bus.mem_req_o), 64'h0);
        nextCycle();
        for (int c = 0; c <= v.gnt_dly; c++) begin
            noiseInputs(noisy);
            bus.mem_gnt_i    = (c == v.gnt_dly);
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = '0;
            @(negedge clk_i);
            checkOutput({tag, " mem_req"},   64'(bus.mem_req_o),   64'h1);
            checkOutput({tag, " mem_wen"},   64'(bus.mem_wen_o),   64'(v.exp_wen));
            checkOutput({tag, " mem_addr"},  64'(bus.mem_addr_o),  64'(v.exp_addr));
            checkOutput({tag, " mem_mask"},  64'(bus.mem_mask_o),  64'(v.exp_mask));
            checkOutput({tag, " mem_wdata"}, bus.mem_wdata_o,      v.exp_wdata);
            checkOutput({tag, " req_gnts"},  64'({bus.ifu_gnt_o, bus.lsu_gnt_o}), 64'h0);
            checkOutput({tag, " req_rvs"},   64'({bus.ifu_rvalid_o, bus.lsu_rvalid_o}), 64'h0);
            nextCycle();
        end
        for (int c = 0; c <= v.rv_dly; c++) begin
            noiseInputs(noisy);
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = (c == v.rv_dly);
            bus.mem_rdata_i  = (c == v.rv_dly) ? v.rdata : {$urandom, $urandom};
            @(negedge clk_i);
            checkOutput({tag, " wait_req"},  64'(bus.mem_req_o), 64'h0);
            checkOutput({tag, " wait_gnts"}, 64'({bus.ifu_gnt_o, bus.lsu_gnt_o}), 64'h0);
            if (c == v.rv_dly) begin
                checkOutput({tag, " ifu_rvalid"}, 64'(bus.ifu_rvalid_o), 64'(!v.exp_lsu));
                checkOutput({tag, " lsu_rvalid"}, 64'(bus.lsu_rvalid_o), 64'(v.exp_lsu));
                checkOutput({tag, " ifu_rdata"},  bus.ifu_rdata_o, v.exp_lsu ? 64'h0 : v.exp_rdata);
                checkOutput({tag, " lsu_rdata"},  bus.lsu_rdata_o, v.exp_lsu ? v.exp_rdata : 64'h0);
            end else begin
                checkOutput({tag, " early_rvs"},   64'({bus.ifu_rvalid_o, bus.lsu_rvalid_o}), 64'h0);
                checkOutput({tag, " early_rdata"}, bus.ifu_rdata_o | bus.lsu_rdata_o, 64'h0);
            end
            nextCycle();
        end
        idleInputs();
    endtask

    initial begin
        // Directed vectors; field order matches vec_t:
        // ifu_req, ifu_addr, lsu_req, lsu_wen, lsu_addr, lsu_mask, lsu_wdata,
        // gnt_dly, rv_dly, rdata, exp_lsu, exp_wen, exp_addr, exp_mask, exp_wdata, exp_rdata
        vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0,
                    0, 0, 64'h13, 1'b0, 1'b0, 32'h8000_0000, 8'hFF, 64'h0, 64'h13};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000, 8'h0F, 64'hDEAD_BEEF,
                    3, 0, 64'h1234, 1'b1, 1'b1, 32'h8000_1000, 8'h0F, 64'hDEAD_BEEF, 64'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_2008, 8'hFF, 64'h55,
                    1, 2, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0, 32'h8000_2008, 8'hFF, 64'h55,
                    64'hCAFE_F00D_1234_5678};
        vecs[3] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 8'h3C, 64'h0,
                    0, 1, 64'hABCD, 1'b1, 1'b0, 32'h200, 8'h3C, 64'h0, 64'hABCD};
        vecs[4] = '{1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h40, 8'h01, 64'h99,
                    2, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFF8, 8'hFF, 64'h0,
                    64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
                    0, 0, 64'h7777, 1'b1, 1'b1, 32'h8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

        // Reset state, with both requesters pushing during reset.
        idleInputs();
        rst_i = 1'b1;
        bus.ifu_req_i = 1'b1;
        bus.lsu_req_i = 1'b1;
        nextCycle();
        @(negedge clk_i);
        checkOutput("rst_gnts", 64'({bus.ifu_gnt_o, bus.lsu_gnt_o}), 64'h0);
        checkOutput("rst_rvs",  64'({bus.ifu_rvalid_o, bus.lsu_rvalid_o}), 64'h0);
        checkOutput("rst_rdata", bus.ifu_rdata_o | bus.lsu_rdata_o, 64'h0);
        checkOutput("rst_mem_req", 64'(bus.mem_req_o), 64'h0);
        checkOutput("rst_mem_fields",
                    64'({bus.mem_wen_o, bus.mem_mask_o}) | 64'(bus.mem_addr_o) | bus.mem_wdata_o, 64'h0);
        checkOutput("rst_state",  64'(dut.state_q), 64'(ST_IDLE));
        checkOutput("rst_streak", 64'(dut.u_sel.streak_q), 64'h0);
        doReset();

        // Directed table.
        for (int i = 0; i < NUM_VECS; i++) begin
            doReset();
            applyStimulus(vecs[i], $sformatf("vec%0d", i), i >= 3);
        end

        // Both requesters held high: grant order L,L,I repeating, streak 1,2,0.
        doReset();
        bus.ifu_req_i  = 1'b1;
        bus.ifu_addr_i = 32'h1000;
        bus.lsu_req_i  = 1'b1;
        bus.lsu_addr_i = 32'h2000;
        bus.lsu_mask_i = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            checkOutput($sformatf("order%0d lsu_gnt", k), 64'(bus.lsu_gnt_o), 64'((k % 3) != 2));
            checkOutput($sformatf("order%0d ifu_gnt", k), 64'(bus.ifu_gnt_o), 64'((k % 3) == 2));
            nextCycle();
            bus.mem_gnt_i = 1'b1;
            @(negedge clk_i);
            checkOutput($sformatf("order%0d streak", k), 64'(dut.u_sel.streak_q),
                        64'(((k % 3) == 2) ? 0 : (k % 3) + 1));
            checkOutput($sformatf("order%0d req_gnts", k), 64'({bus.ifu_gnt_o, bus.lsu_gnt_o}), 64'h0);
            nextCycle();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 64'(k + 1);
            @(negedge clk_i);
            checkOutput($sformatf("order%0d wait_gnts", k), 64'({bus.ifu_gnt_o, bus.lsu_gnt_o}), 64'h0);
            checkOutput($sformatf("order%0d rdata", k),
                        ((k % 3) == 2) ? bus.ifu_rdata_o : bus.lsu_rdata_o, 64'(k + 1));
            nextCycle();
            bus.mem_rvalid_i = 1'b0;
        end

        // Reset in WAIT followed by a late response.
        doReset();
        bus.ifu_req_i = 1'b1;
        bus.lsu_req_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstwait lsu_gnt", 64'(bus.lsu_gnt_o), 64'h1);
        nextCycle();
        bus.ifu_req_i = 1'b0;
        bus.lsu_req_i = 1'b0;
        bus.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstwait streak_pre", 64'(dut.u_sel.streak_q), 64'h1);
        nextCycle();
        bus.mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstwait rvs_in_rst", 64'({bus.ifu_rvalid_o, bus.lsu_rvalid_o}), 64'h0);
        nextCycle();
        rst_i = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hBAD;
        @(negedge clk_i);
        checkOutput("rstwait rvs_late", 64'({bus.ifu_rvalid_o, bus.lsu_rvalid_o}), 64'h0);
        checkOutput("rstwait rdata_late", bus.ifu_rdata_o | bus.lsu_rdata_o, 64'h0);
        checkOutput("rstwait mem_req", 64'(bus.mem_req_o), 64'h0);
        checkOutput("rstwait state", 64'(dut.state_q), 64'(ST_IDLE));
        checkOutput("rstwait streak", 64'(dut.u_sel.streak_q), 64'h0);
        nextCycle();
        idleInputs();
        @(negedge clk_i);
        checkOutput("rstwait still_idle", 64'(bus.mem_req_o), 64'h0);
        nextCycle();

        // A response while still in REQ is ignored; only the later one is delivered.
        doReset();
        bus.lsu_req_i  = 1'b1;
        bus.lsu_addr_i = 32'h3000;
        bus.lsu_mask_i = 8'hF0;
        @(negedge clk_i);
        checkOutput("reqrv lsu_gnt", 64'(bus.lsu_gnt_o), 64'h1);
        nextCycle();
        bus.lsu_req_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hBAD1;
        @(negedge clk_i);
        checkOutput("reqrv early_rvalid", 64'(bus.lsu_rvalid_o), 64'h0);
        checkOutput("reqrv early_rdata", bus.lsu_rdata_o, 64'h0);
        checkOutput("reqrv mem_req", 64'(bus.mem_req_o), 64'h1);
        nextCycle();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_gnt_i    = 1'b1;
        @(negedge clk_i);
        checkOutput("reqrv still_req", 64'(bus.mem_req_o), 64'h1);
        nextCycle();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h600D;
        @(negedge clk_i);
        checkOutput("reqrv lsu_rvalid", 64'(bus.lsu_rvalid_o), 64'h1);
        checkOutput("reqrv lsu_rdata", bus.lsu_rdata_o, 64'h600D);
        checkOutput("reqrv ifu_rvalid", 64'(bus.ifu_rvalid_o), 64'h0);
        nextCycle();
        idleInputs();

        // Randomized transactions against the arbitration rules.
        doReset();
        for (int t = 0; t < NUM_RAND; t++) begin
            vec_t v;
            logic ir;
            logic lr;
            logic lsu_wins;
            ir = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            if (!ir && !lr) begin
                idleInputs();
                @(negedge clk_i);
                checkOutput($sformatf("rnd%0d none_gnt", t), 64'({bus.ifu_gnt_o, bus.lsu_gnt_o}), 64'h0);
                checkOutput($sformatf("rnd%0d none_req", t), 64'(bus.mem_req_o), 64'h0);
                nextCycle();
                continue;
            end
            v.ifu_req   = ir;
            v.ifu_addr  = $urandom;
            v.lsu_req   = lr;
            v.lsu_wen   = 1'($urandom_range(0, 1));
            v.lsu_addr  = $urandom;
            v.lsu_mask  = 8'($urandom);
            v.lsu_wdata = {$urandom, $urandom};
            v.gnt_dly   = $urandom_range(0, 3);
            v.rv_dly    = $urandom_range(0, 3);
            v.rdata     = {$urandom, $urandom};
            lsu_wins    = lr && !(ir && model_streak >= MAX_STREAK);
            if (lsu_wins) begin
                if (ir) model_streak = (model_streak + 1 > MAX_STREAK) ? MAX_STREAK : model_streak + 1;
            end else begin
                model_streak = 0;
            end
            v.exp_lsu   = lsu_wins;
            v.exp_wen   = lsu_wins ? v.lsu_wen : 1'b0;
            v.exp_addr  = lsu_wins ? v.lsu_addr : v.ifu_addr;
            v.exp_mask  = lsu_wins ? v.lsu_mask : 8'hFF;
            v.exp_wdata = lsu_wins ? v.lsu_wdata : 64'h0;
            v.exp_rdata = (lsu_wins && v.lsu_wen) ? 64'h0 : v.rdata;
            applyStimulus(v, $sformatf("rnd%0d", t), 1'b1);
            checkOutput($sformatf("rnd%0d streak", t), 64'(dut.u_sel.streak_q), 64'(model_streak));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
